// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// State encodings and default datapath widths.
package alu_arbiter_pkg;

    localparam int ALU_W     = 8;
    localparam int ALU_SEL_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant with a single pointer flop.
// The pointer moves past the served requester on advance.
module rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       owner,
    output logic [1:0] grant
);

    logic ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~owner;
        end
    end

    always_comb begin
        grant = req;
        if (&req) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int SEL_W = ALU_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
);

    state_t     state;
    logic       owner;
    logic [1:0] req;
    logic [1:0] grant;
    logic       idle;
    logic       rsp_hs;

    assign idle = (state == ST_IDLE);
    assign req  = {req1_valid, req0_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (rsp_hs),
        .owner   (owner),
        .grant   (grant)
    );

    assign req0_ready = idle & grant[0];
    assign req1_ready = idle & grant[1];
    assign rsp0_valid = (state == ST_RESP) & ~owner;
    assign rsp1_valid = (state == ST_RESP) & owner;
    assign busy       = ~idle;

    assign rsp_hs = owner ? (rsp1_valid & rsp1_ready)
                          : (rsp0_valid & rsp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp0_data <= '0;
            rsp1_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state   <= ST_EXEC;
                        owner   <= grant[1];
                        alu_a   <= grant[1] ? req1_a : req0_a;
                        alu_b   <= grant[1] ? req1_b : req0_b;
                        alu_sel <= grant[1] ? req1_sel : req0_sel;
                    end
                end
                ST_EXEC: begin
                    if (owner) begin
                        rsp1_data <= alu_out;
                    end else begin
                        rsp0_data <= alu_out;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
